// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - data-RAM responder with fixed access latency and core stall
// Optional one-entry read buffer enabled by defining RAM_CTRL_READ_BUF_EN.
module ram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_valid_i,
    input  logic        ram_write_i,
    input  logic [3:0]  ram_byte_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_wdata_i,
    output logic [31:0] ram_data_o,
    output logic        stall_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    req_write_q, req_write_d;
    logic [3:0]              req_byte_q, req_byte_d;
    logic [ADDR_WIDTH-1:0]   req_word_q, req_word_d;
    logic [31:0]             req_wdata_q, req_wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0]   word_in;
    logic                    access;
    logic                    do_store;
    logic                    hit;

    assign word_in = ram_addr_i[ADDR_WIDTH+1:2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_write_d = req_write_q;
        req_byte_d  = req_byte_q;
        req_word_d  = req_word_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        stall_o     = 1'b0;
        access      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_valid_i && !hit) begin
                    stall_o     = 1'b1;
                    req_write_d = ram_write_i;
                    req_byte_d  = ram_byte_i;
                    req_word_d  = word_in;
                    req_wdata_d = ram_wdata_i;
                    cnt_d       = CNT_INIT;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = DONE;
                    if (!req_write_q) begin
                        rdata_d = mem[req_word_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_write_q <= 1'b0;
            req_byte_q  <= 4'd0;
            req_word_q  <= '0;
            req_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_write_q <= req_write_d;
            req_byte_q  <= req_byte_d;
            req_word_q  <= req_word_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Array contents survive reset; a store caught by reset is dropped.
    assign do_store = access && req_write_q && !rst;

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (req_byte_q[i]) begin
                    mem[req_word_q][8*i +: 8] <= req_wdata_q[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_CTRL_READ_BUF_EN
    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0] buf_word_q, buf_word_d;
    logic [31:0]           buf_data_q, buf_data_d;

    assign hit = (state_q == IDLE) && ram_valid_i && !ram_write_i
                 && buf_valid_q && (word_in == buf_word_q);

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_word_d  = buf_word_q;
        buf_data_d  = buf_data_q;
        if (access) begin
            if (!req_write_q) begin
                buf_valid_d = 1'b1;
                buf_word_d  = req_word_q;
                buf_data_d  = rdata_d;
            end else if (req_word_q == buf_word_q) begin
                buf_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= 32'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_word_q  <= buf_word_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign ram_data_o = hit ? buf_data_q : rdata_q;
`else
    assign hit        = 1'b0;
    assign ram_data_o = rdata_q;
`endif
endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - scoreboard bench for ram_ctrl
module tb_ram_ctrl;
    localparam int LAT   = 2;
    localparam int LIMIT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_valid_i;
    logic        ram_write_i;
    logic [3:0]  ram_byte_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_wdata_i;
    logic [31:0] ram_data_o;
    logic        stall_o;

    ram_ctrl #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_valid_i (ram_valid_i),
        .ram_write_i (ram_write_i),
        .ram_byte_i  (ram_byte_i),
        .ram_addr_i  (ram_addr_i),
        .ram_wdata_i (ram_wdata_i),
        .ram_data_o  (ram_data_o),
        .stall_o     (stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          run   = 0;
    logic [31:0] last_data = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a completed request is a falling edge of a stall run.
    always @(negedge clk) begin
        if (rst) begin
            run       = 0;
            last_data = 32'd0;
        end else if (stall_o) begin
            run++;
            n_cmp++;
            if (ram_data_o !== last_data) begin
                n_err++;
                $display("FAIL hold_data: got %h want %h", ram_data_o, last_data);
            end
        end else if (run > 0) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got completion want none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (run != LAT + 1) begin
                    n_err++;
                    $display("FAIL stall_len: got %0d want %0d", run, LAT + 1);
                end
                if (e.is_load) begin
                    n_cmp++;
                    if (ram_data_o !== e.data) begin
                        n_err++;
                        $display("FAIL load_data: got %h want %h", ram_data_o, e.data);
                    end
                    last_data = e.data;
                end
            end
            run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic req(input logic w, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] expd,
                       output int start_c, output int done_c);
        exp_t e;
        int n;
        e.is_load = !w;
        e.data    = expd;
        sb_q.push_back(e);
        ram_valid_i = 1'b1;
        ram_write_i = w;
        ram_byte_i  = be;
        ram_addr_i  = addr;
        ram_wdata_i = wd;
        start_c = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall_o && n < LIMIT);
        done_c = cyc;
        if (n >= LIMIT) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got stall after %0d cycles want release", n);
        end
        @(posedge clk);
        #1;
        ram_valid_i = 1'b0;
    endtask

    int s0, d0, s1, d1;

    initial begin
        rst = 1'b1;
        ram_valid_i = 1'b0;
        ram_write_i = 1'b0;
        ram_byte_i  = 4'd0;
        ram_addr_i  = 32'd0;
        ram_wdata_i = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_data", ram_data_o, 32'd0);
        @(posedge clk);
        #1;

        req(1'b1, 4'b1111, 32'h40,   32'hDEADBEEF, 32'h0,        s0, d0);
        req(1'b0, 4'b0000, 32'h40,   32'h0,        32'hDEADBEEF, s0, d0);
        req(1'b1, 4'b0100, 32'h40,   32'h00AA0000, 32'h0,        s0, d0);
        req(1'b0, 4'b0000, 32'h42,   32'h0,        32'hDEAABEEF, s0, d0);
        req(1'b1, 4'b0000, 32'h40,   32'hFFFFFFFF, 32'h0,        s0, d0);
        req(1'b0, 4'b0000, 32'h4041, 32'h0,        32'hDEAABEEF, s0, d0);
        req(1'b1, 4'b1111, 32'h44,   32'h12345678, 32'h0,        s0, d0);

        req(1'b0, 4'b0000, 32'h40,   32'h0,        32'hDEAABEEF, s0, d0);
        req(1'b0, 4'b0000, 32'h44,   32'h0,        32'h12345678, s1, d1);
        check("b2b_second_start", 32'(s1 - s0), 32'd4);
        check("b2b_second_done",  32'(d1 - s0), 32'd7);

        req(1'b1, 4'b1111, 32'h80,   32'h11111111, 32'h0,        s0, d0);

        // Store aborted by reset while still counting down.
        ram_valid_i = 1'b1;
        ram_write_i = 1'b1;
        ram_byte_i  = 4'b1111;
        ram_addr_i  = 32'h80;
        ram_wdata_i = 32'h22222222;
        @(posedge clk);
        #1;
        ram_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_stall", {31'd0, stall_o}, 32'd0);
        check("post_reset_data", ram_data_o, 32'd0);
        @(posedge clk);
        #1;
        req(1'b0, 4'b0000, 32'h80,   32'h0,        32'h11111111, s0, d0);

`ifdef RAM_CTRL_READ_BUF_EN
        req(1'b0, 4'b0000, 32'h40,   32'h0,        32'hDEAABEEF, s0, d0);
        ram_valid_i = 1'b1;
        ram_write_i = 1'b0;
        ram_addr_i  = 32'h40;
        @(negedge clk);
        check("hit_stall", {31'd0, stall_o}, 32'd0);
        check("hit_data", ram_data_o, 32'hDEAABEEF);
        @(posedge clk);
        #1;
        ram_valid_i = 1'b0;
        req(1'b1, 4'b1111, 32'h40,   32'hCAFEF00D, 32'h0,        s0, d0);
        req(1'b0, 4'b0000, 32'h40,   32'h0,        32'hCAFEF00D, s0, d0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Data-RAM responder for the pipeline's memory stage. It accepts the load and store requests the core issues on its RAM port and services them against an internal word-organised array after a fixed access latency. While a request is pending it holds the core's memory stall so the pipeline freezes. It sits between the core's memory-stage outputs and its `ram_data_i` / `stall_from_ram` inputs.

## Interface
- `ADDR_WIDTH`, 12: word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: array access cycles, legal range 1..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ram_valid_i`  in  1  request present.
- `ram_write_i`  in  1  1 = store, 0 = load.
- `ram_byte_i`  in  4  store byte enables; bit i writes bits [8i+7:8i] (little-endian).
- `ram_addr_i`  in  32  byte address; word index is `ram_addr_i[ADDR_WIDTH+1:2]`; bits [1:0] and the upper bits are ignored.
- `ram_wdata_i`  in  32  store data, already lane-aligned by the core.
- `ram_data_o`  out  32  load data: a full word, which the core's memory stage extracts from.
- `stall_o`  out  1  freeze request to the core's stall controller.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - `stall_o` = `ram_valid_i`.
  - On `ram_valid_i`=1: latch write, byte, word index and wdata into request registers; load `cnt` = LATENCY-1; go to BUSY.
- **BUSY**
  - `stall_o`=1, whatever the value of `ram_valid_i`.
  - If `cnt`==0, perform the access from the latched request and go to DONE; otherwise decrement `cnt`.
  - Load: `rdata_q` <= array[word].
  - Store: write only the enabled bytes. A store with `ram_byte_i`=0 changes nothing.
- **DONE**
  - `stall_o`=0; the core advances on this edge.
  - Next state is IDLE unconditionally. A new request is seen in the following IDLE cycle.
- `ram_data_o` = `rdata_q`.
  - `rdata_q` holds the last completed load.
  - Stores do not modify `rdata_q`.
- The request is latched at acceptance. Changing or dropping the inputs during BUSY does not affect the access in progress.
- The array is not cleared by reset.

## Timing
- Reset values: state IDLE, `cnt`=0, `rdata_q`=0, so `ram_data_o`=0. `stall_o`=0 unless `ram_valid_i`=1 in IDLE after reset.
- If a request is first visible in cycle t:
  - `stall_o` is high for cycles t .. t+LATENCY.
  - `stall_o` is low in cycle t+LATENCY+1 (DONE), with load data valid on `ram_data_o`.
  - Total stall is LATENCY+1 cycles.
- Back-to-back requests: next request accepted at t+LATENCY+2, so each miss costs LATENCY+2 cycles.
- `stall_o` is combinational from `ram_valid_i` only in IDLE. In BUSY and DONE it is registered-state only.
- Reset mid-operation: return to IDLE next edge. A store not yet performed (still BUSY with `cnt`>0 or just accepted) is discarded; a store already performed is kept.
- Reads return array contents including all previously completed stores; no internal forwarding is needed since accesses are serialised.

## Configuration
- `RAM_CTRL_READ_BUF_EN` defined: adds a one-entry read buffer (`buf_valid`, `buf_word`, `buf_data`).
  - Hit: IDLE, `ram_valid_i`=1, `ram_write_i`=0, `buf_valid`=1, word == `buf_word`.
  - On a hit: `stall_o`=0, `ram_data_o`=`buf_data` combinationally, state stays IDLE, no array access.
  - Every completed load fills the buffer.
  - A completed store to `buf_word` clears `buf_valid`.
  - `rst` clears `buf_valid`.
- Not defined: every request follows the IDLE/BUSY/DONE path; no buffer logic is present.

## Test plan
- Reset, then idle with `ram_valid_i`=0 -> `stall_o`=0, `ram_data_o`=0x00000000.
- Store 0xDEADBEEF, byte=4'b1111, addr 0x40, LATENCY=2; hold until stall drops, then load 0x40 -> stall high 3 cycles for each request; load returns 0xDEADBEEF in its DONE cycle.
- Partial store: byte=4'b0100, wdata=0x00AA0000, to 0x40; then load 0x40 -> 0xDEAABEEF. A store with byte=4'b0000 leaves the word unchanged.
- Back-to-back loads 0x40 then 0x44 -> second stall begins at t+4 and DONE at t+7; load data switches only in each DONE cycle.
- Assert `rst` during BUSY of a store to 0x80 (old value 0x11111111), then load 0x80 -> returns 0x11111111; `stall_o`=0 the cycle after reset.
- With `RAM_CTRL_READ_BUF_EN`:
  - Load 0x40 twice -> second load has `stall_o`=0 in its first cycle with correct data.
  - Store to 0x40, then load 0x40 -> full LATENCY+1 stall.
